// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS bit positions and transmitter state encoding
// shared by mmio_uart_tx and its bench-visible register view.
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_BAUDDIV = 4'h8;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_PARITY  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational read port; push and pop
// may both be accepted on one edge, including a push while full.
`timescale 1ns/1ps
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A pop on the same edge frees the slot a full FIFO needs for the push.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and baud divisor.
// Optional even-parity bit when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
`default_nettype none

module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        hit,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    offset;
  logic          wr_txdata, wr_status, wr_baud;
  logic          fifo_full, fifo_empty, pop;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [31:0]   cnt_wide;
  logic [3:0]    cnt_sat;
  logic [31:0]   status;
  logic          unused_bits;

  logic          ovf_q;
  logic [15:0]   baud_q;
  tx_state_e     state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [15:0]   div_q, div_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          tx_q, tx_d;
  logic          irq_q;
  logic          bit_end, load;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign hit       = (Mem_WrAddr[31:4] == BASE_ADDR[31:4]);
  assign offset    = {Mem_WrAddr[3:2], 2'b00};
  assign wr_txdata = MemWrite && hit && (offset == OFF_TXDATA);
  assign wr_status = MemWrite && hit && (offset == OFF_STATUS);
  assign wr_baud   = MemWrite && hit && (offset == OFF_BAUDDIV);
  assign unused_bits = ^{Mem_WrAddr[1:0], Mem_WrData[31:16]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (wr_txdata),
    .wdata_i (Mem_WrData[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign cnt_wide = 32'(fifo_count);
  assign cnt_sat  = (cnt_wide > 32'd15) ? 4'hF : cnt_wide[3:0];

  always_comb begin
    status                          = '0;
    status[STAT_BUSY]               = (state_q != IDLE);
    status[STAT_FULL]               = fifo_full;
    status[STAT_EMPTY]              = fifo_empty;
    status[STAT_OVF]                = ovf_q;
    status[STAT_CNT_LSB +: 4]       = cnt_sat;
`ifdef UART_TX_PARITY_EN
    status[STAT_PARITY]             = 1'b1;
`endif
  end

  always_comb begin
    ReadData = '0;
    if (hit) begin
      case (offset)
        OFF_STATUS:  ReadData = status;
        OFF_BAUDDIV: ReadData = {16'h0000, baud_q};
        default:     ReadData = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q  <= 1'b0;
      baud_q <= DIV_RESET;
    end else begin
      if (wr_txdata && fifo_full && !pop) ovf_q <= 1'b1;
      else if (wr_status && Mem_WrData[STAT_OVF]) ovf_q <= 1'b0;
      if (wr_baud) baud_q <= Mem_WrData[15:0];
    end
  end

  assign bit_end = (timer_q == div_q);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    div_d    = div_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    load     = 1'b0;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    if (state_q != IDLE) timer_d = bit_end ? 16'd0 : timer_q + 16'd1;
    case (state_q)
      IDLE:  load = !fifo_empty;
      START: if (bit_end) begin
        state_d  = DATA;
        bitcnt_d = 3'd0;
      end
      DATA: if (bit_end) begin
        if (bitcnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          shift_d  = {1'b0, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) begin
        if (!fifo_empty) load = 1'b1;
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The divisor is captured per frame so BAUDDIV writes only affect later frames.
    if (load) begin
      pop     = 1'b1;
      state_d = START;
      timer_d = 16'd0;
      div_d   = baud_q;
      shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_rdata;
`endif
    end
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      div_q    <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      div_q    <= div_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      tx_q     <= tx_d;
      irq_q    <= (state_q == IDLE) && fifo_empty;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign tx  = tx_q;
  assign irq = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: register-map vector table, exact-timing frame sequences and
// randomized bursts checked by a line-level UART receiver model.
`timescale 1ns/1ps
`default_nettype none

module tb_mmio_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int          NB       = 11;
  localparam logic [31:0] PAR_FLAG = 32'h100;
`else
  localparam int          NB       = 10;
  localparam logic [31:0] PAR_FLAG = 32'h000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [31:0] ReadData;
  logic        hit;
  logic        tx;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_hit;
    logic [31:0] exp_rd;
  } vec_t;

  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic       rx_ok[$];
  logic       mon_en = 1'b0;
  int         mon_p  = 1;

  mmio_uart_tx #(
    .BASE_ADDR  (32'h0000_1000),
    .FIFO_DEPTH (8),
    .DIV_RESET  (16'd433)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .Mem_WrAddr (Mem_WrAddr),
    .Mem_WrData (Mem_WrData),
    .ReadData   (ReadData),
    .hit        (hit),
    .tx         (tx),
    .irq        (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; the store lands on the following posedge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    MemWrite   = 1'b1;
    Mem_WrAddr = addr;
    Mem_WrData = data;
    @(negedge clk);
    MemWrite   = 1'b0;
    Mem_WrAddr = 32'h0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    Mem_WrAddr = addr;
    #1;
    data = ReadData;
  endtask

  // Line image of one frame, index 0 = start bit, LSB-first data, optional even parity, stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] v;
    v      = '1;
    v[0]   = 1'b0;
    v[8:1] = b;
`ifdef UART_TX_PARITY_EN
    v[9]   = ^b;
`endif
    return v;
  endfunction

  // Entered at the first negedge of a start bit; samples the first clock of every bit.
  task automatic check_frame(input logic [7:0] b, input int p, input string name);
    logic [10:0] obs;
    obs    = '1;
    obs[0] = tx;
    for (int k = 1; k < NB; k++) begin
      repeat (p) @(negedge clk);
      obs[k] = tx;
    end
    chk(name, 32'(obs), 32'(exp_frame(b)));
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (irq !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(irq), 32'h1);
  endtask

  initial begin : monitor
    logic [10:0] mb;
    int          mp;
    int          mt;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        mp    = mon_p;
        mt    = cyc;
        mb    = '1;
        mb[0] = 1'b0;
        for (int k = 1; k < NB; k++) begin
          repeat (mp) @(negedge clk);
          mb[k] = tx;
        end
        rx_q.push_back(mb[8:1]);
        rx_t.push_back(mt);
        rx_ok.push_back(mb == exp_frame(mb[8:1]));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t        tbl[13];
    logic [31:0] r;
    logic [7:0]  b;
    logic [7:0]  exp_q[$];
    int          lows;
    int          div;
    int          n;

    reset      = 1'b0;
    MemWrite   = 1'b0;
    Mem_WrAddr = 32'h0;
    Mem_WrData = 32'h0;
    repeat (3) @(negedge clk);
    chk("tx_in_reset", 32'(tx), 32'h1);
    chk("irq_in_reset", 32'(irq), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("tx_after_reset", 32'(tx), 32'h1);
    chk("irq_after_reset", 32'(irq), 32'h1);

    tbl[0]  = '{1'b0, 32'h0000_1004, 32'h0,         1'b1, 32'h4 | PAR_FLAG};
    tbl[1]  = '{1'b0, 32'h0000_1008, 32'h0,         1'b1, 32'd433};
    tbl[2]  = '{1'b0, 32'h0000_100C, 32'h0,         1'b1, 32'h0};
    tbl[3]  = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0};
    tbl[4]  = '{1'b0, 32'h0000_2004, 32'h0,         1'b0, 32'h0};
    tbl[5]  = '{1'b0, 32'h0000_1010, 32'h0,         1'b0, 32'h0};
    tbl[6]  = '{1'b1, 32'h0000_1008, 32'hFFFF_0003, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 32'h0000_1008, 32'h0,         1'b1, 32'h3};
    tbl[8]  = '{1'b1, 32'h0000_100C, 32'h1234_5678, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 32'h0000_100C, 32'h0,         1'b1, 32'h0};
    tbl[10] = '{1'b1, 32'h0000_1004, 32'hFFFF_FFFF, 1'b1, 32'h0};
    tbl[11] = '{1'b0, 32'h0000_1004, 32'h0,         1'b1, 32'h4 | PAR_FLAG};
    tbl[12] = '{1'b0, 32'h0000_1007, 32'h0,         1'b1, 32'h4 | PAR_FLAG};

    for (int i = 0; i < 13; i++) begin
      Mem_WrAddr = tbl[i].addr;
      Mem_WrData = tbl[i].wdata;
      MemWrite   = tbl[i].we;
      #1;
      chk($sformatf("vec%0d_hit", i), 32'(hit), 32'(tbl[i].exp_hit));
      if (!tbl[i].we) chk($sformatf("vec%0d_rdata", i), ReadData, tbl[i].exp_rd);
      @(negedge clk);
      MemWrite = 1'b0;
    end
    chk("tx_idle_after_regs", 32'(tx), 32'h1);

    // Single 0xA5 frame at 4 clocks/bit with exact edge timing.
    wr(32'h1008, 32'd3);
    wr(32'h1000, 32'hA5);
    rd(32'h1004, r);
    chk("a5_status_after_push", r, 32'h10 | PAR_FLAG);
    chk("a5_tx_before_pop", 32'(tx), 32'h1);
    chk("a5_irq_before_fall", 32'(irq), 32'h1);
    @(negedge clk);
    chk("a5_irq_fell", 32'(irq), 32'h0);
    rd(32'h1004, r);
    chk("a5_status_busy", r, 32'h5 | PAR_FLAG);
    check_frame(8'hA5, 4, "a5_frame");
    rd(32'h1004, r);
    chk("a5_busy_in_stop", r, 32'h5 | PAR_FLAG);
    repeat (3) @(negedge clk);
    chk("a5_irq_low_at_stop_end", 32'(irq), 32'h0);
    repeat (2) @(negedge clk);
    chk("a5_irq_back_high", 32'(irq), 32'h1);
    chk("a5_tx_idle", 32'(tx), 32'h1);
    rd(32'h1004, r);
    chk("a5_status_idle", r, 32'h4 | PAR_FLAG);

    // Ten back-to-back stores: first pops immediately, eight fill the FIFO, the tenth is dropped.
    @(negedge clk);
    exp_q.delete(); rx_q.delete(); rx_t.delete(); rx_ok.delete();
    mon_p  = 4;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      if (i < 9) exp_q.push_back(b);
      wr(32'h1000, {24'h0, b});
    end
    rd(32'h1004, r);
    chk("burst_status_full_ovf", r, 32'h8B | PAR_FLAG);
    wait_idle("burst_idle");
    mon_en = 1'b0;
    chk("burst_frame_count", 32'(rx_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      chk($sformatf("burst_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
      chk($sformatf("burst_framing%0d", i), 32'(rx_ok[i]), 32'h1);
      if (i > 0) chk($sformatf("burst_gap%0d", i), 32'(rx_t[i] - rx_t[i-1]), 32'(4 * NB));
    end
    rd(32'h1004, r);
    chk("burst_ovf_set", 32'(r[3]), 32'h1);
    @(negedge clk);
    wr(32'h1004, 32'h8);
    rd(32'h1004, r);
    chk("burst_ovf_cleared", r, 32'h4 | PAR_FLAG);

    // BAUDDIV write mid-frame: first frame keeps 4 clocks/bit, second uses 2.
    @(negedge clk);
    wr(32'h1000, 32'h3C);
    wr(32'h1000, 32'hC3);
    fork
      check_frame(8'h3C, 4, "midchg_frame1_div3");
      begin
        repeat (10) @(negedge clk);
        wr(32'h1008, 32'd1);
      end
    join
    repeat (4) @(negedge clk);
    check_frame(8'hC3, 2, "midchg_frame2_div1");
    wait_idle("midchg_idle");
    rd(32'h1008, r);
    chk("midchg_bauddiv", r, 32'd1);

    // Asynchronous reset during DATA of an all-zero byte with two more queued.
    @(negedge clk);
    wr(32'h1008, 32'd3);
    wr(32'h1000, 32'h00);
    wr(32'h1000, 32'h11);
    wr(32'h1000, 32'h22);
    repeat (8) @(negedge clk);
    chk("rst_tx_low_in_data", 32'(tx), 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_tx_immediate", 32'(tx), 32'h1);
    chk("rst_irq_immediate", 32'(irq), 32'h1);
    rd(32'h1004, r);
    chk("rst_status", r, 32'h4 | PAR_FLAG);
    rd(32'h1008, r);
    chk("rst_bauddiv", r, 32'd433);
    @(negedge clk);
    reset = 1'b1;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("rst_no_frame_after", 32'(lows), 32'h0);
    chk("rst_irq_stays_high", 32'(irq), 32'h1);

    // Randomized bursts with gaps, decoded by the receiver model.
    for (int it = 0; it < 6; it++) begin
      div = int'($urandom_range(0, 3));
      wr(32'h1008, 32'(div));
      exp_q.delete(); rx_q.delete(); rx_t.delete(); rx_ok.delete();
      mon_p  = div + 1;
      mon_en = 1'b1;
      n = int'($urandom_range(1, 8));
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        wr(32'h1000, {24'h0, b});
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle($sformatf("rand%0d_idle", it));
      mon_en = 1'b0;
      chk($sformatf("rand%0d_count", it), 32'(rx_q.size()), 32'(n));
      for (int j = 0; j < n && j < rx_q.size(); j++) begin
        chk($sformatf("rand%0d_byte%0d", it, j), 32'(rx_q[j]), 32'(exp_q[j]));
        chk($sformatf("rand%0d_framing%0d", it, j), 32'(rx_ok[j]), 32'h1);
      end
    end

`ifdef UART_TX_PARITY_EN
    @(negedge clk);
    wr(32'h1008, 32'd0);
    wr(32'h1000, 32'h07);
    @(negedge clk);
    check_frame(8'h07, 1, "parity_frame_0x07");
    wait_idle("parity_idle");
`endif
    rd(32'h1004, r);
    chk("status_parity_flag", r & 32'h100, PAR_FLAG);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
